// File: rtl/detector_pkg.sv
// Shared definitions for the serial pattern detector: 7-segment codes,
// counter FSM state encoding and the hex-to-segment helper.
package detector_pkg;

  // Active-high segment codes, bit7 = 0, bits 6..0 = gfedcba
  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;
  localparam logic [7:0] SEG_A = 8'h77;
  localparam logic [7:0] SEG_B = 8'h7C;
  localparam logic [7:0] SEG_C = 8'h39;
  localparam logic [7:0] SEG_D = 8'h5E;
  localparam logic [7:0] SEG_E = 8'h79;
  localparam logic [7:0] SEG_F = 8'h71;

  // Match counter states; CHEIO is the sticky overflow state
  typedef enum logic [0:0] {
    CONTANDO = 1'b0,
    CHEIO    = 1'b1
  } estado_t;

  function automatic logic [7:0] hex_para_seg(input logic [3:0] valor);
    logic [7:0] seg;
    case (valor)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/decod_7seg.sv
// Hex digit to active-high 7-segment code (bit7 unused, always 0).
module decod_7seg
  import detector_pkg::*;
(
  input  logic [3:0] valor_i,
  output logic [7:0] seg_o
);

  // Pure lookup, no state
  always_comb begin
    seg_o = hex_para_seg(valor_i);
  end

endmodule

// File: rtl/detector_sequencia_param.sv
// Parametrised serial pattern detector with match counter, sticky
// overflow flag and hex readout of the low counter nibble.
module detector_sequencia_param
  import detector_pkg::*;
#(
  parameter int                      NBITS_PADRAO   = 3,
  parameter logic [NBITS_PADRAO-1:0] PADRAO         = 'b111,
  parameter int                      NBITS_CONTAGEM = 4,
  parameter bit                      SOBREPOSICAO   = 1'b1,
  parameter bit                      SATURA         = 1'b0
) (
  input  logic                      clk_2,
  input  logic                      reset,
  input  logic                      bit_valido,
  input  logic                      bit_entrada,
  input  logic                      limpa_contagem,
  input  logic                      load,
  input  logic [NBITS_CONTAGEM-1:0] valor_inicial,
  output logic                      detectado,
  output logic [NBITS_CONTAGEM-1:0] contagem,
  output logic                      cheio,
  output logic [7:0]                SEG
);

  localparam int                      PW        = $clog2(NBITS_PADRAO + 1);
  localparam logic [PW-1:0]           CHEIA     = PW'(NBITS_PADRAO);
  localparam logic [NBITS_CONTAGEM-1:0] MAX_CONT = '1;

  logic [NBITS_PADRAO-1:0]   janela_q, janela_d;
  logic [PW-1:0]             preenchidos_q, preenchidos_d;
  logic                      detectado_q;
  logic                      casa;
  logic [NBITS_CONTAGEM-1:0] contagem_q, contagem_d;
  estado_t                   estado_q, estado_d;

  // Candidate window/fill level if the current bit is accepted, and match test
  always_comb begin
    janela_d      = {janela_q[NBITS_PADRAO-2:0], bit_entrada};
    preenchidos_d = (preenchidos_q == CHEIA) ? CHEIA : preenchidos_q + PW'(1);
    casa          = bit_valido && (preenchidos_d == CHEIA) && (janela_d == PADRAO);
  end

  // Detector: shift accepted bits, track fill level, register the match pulse
  always_ff @(posedge clk_2) begin
    if (reset) begin
      janela_q      <= '0;
      preenchidos_q <= '0;
      detectado_q   <= 1'b0;
    end else if (bit_valido) begin
      janela_q      <= janela_d;
      // Without overlap a match restarts the fill so N fresh bits are needed
      preenchidos_q <= (!SOBREPOSICAO && casa) ? '0 : preenchidos_d;
      detectado_q   <= casa;
    end else begin
      detectado_q   <= 1'b0;
    end
  end

  // Counter FSM state register
  always_ff @(posedge clk_2) begin
    if (reset) begin
      estado_q   <= CONTANDO;
      contagem_q <= '0;
    end else begin
      estado_q   <= estado_d;
      contagem_q <= contagem_d;
    end
  end

  // Counter FSM next state: clear > load > match
  always_comb begin
    estado_d   = estado_q;
    contagem_d = contagem_q;
    if (limpa_contagem) begin
      estado_d   = CONTANDO;
      contagem_d = '0;
    end else if (load) begin
      estado_d   = CONTANDO;
      contagem_d = valor_inicial;
    end else if (casa) begin
      if (contagem_q != MAX_CONT) begin
        contagem_d = contagem_q + NBITS_CONTAGEM'(1);
      end else begin
        estado_d   = CHEIO;
        contagem_d = SATURA ? MAX_CONT : '0;
      end
    end
  end

  // Counter FSM outputs
  always_comb begin
    cheio     = (estado_q == CHEIO);
    contagem  = contagem_q;
    detectado = detectado_q;
  end

  decod_7seg u_decod (
    .valor_i (contagem_q[3:0]),
    .seg_o   (SEG)
  );

endmodule

// File: tb/tb_detector_sequencia_param.sv
// Bench for detector_sequencia_param: four configurations share one input
// stream and are checked against a queue-based reference model.
module tb_detector_sequencia_param;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic       bit_valido = 1'b0;
  logic       bit_entrada = 1'b0;
  logic       limpa_contagem = 1'b0;
  logic       load = 1'b0;
  logic [4:0] valor_inicial = '0;

  always #5 clk_2 = ~clk_2;

  logic       det_w   [4];
  logic       cheio_w [4];
  logic [7:0] seg_w   [4];
  logic [7:0] cnt_w   [4];
  logic [3:0] cnt0, cnt1, cnt2;
  logic [4:0] cnt3;

  assign cnt_w[0] = {4'b0, cnt0};
  assign cnt_w[1] = {4'b0, cnt1};
  assign cnt_w[2] = {4'b0, cnt2};
  assign cnt_w[3] = {3'b0, cnt3};

  // u0: defaults (overlap, wrap)
  detector_sequencia_param #(.NBITS_PADRAO(3), .PADRAO(3'b111), .NBITS_CONTAGEM(4),
    .SOBREPOSICAO(1'b1), .SATURA(1'b0)) u0 (
    .clk_2(clk_2), .reset(reset), .bit_valido(bit_valido), .bit_entrada(bit_entrada),
    .limpa_contagem(limpa_contagem), .load(load), .valor_inicial(valor_inicial[3:0]),
    .detectado(det_w[0]), .contagem(cnt0), .cheio(cheio_w[0]), .SEG(seg_w[0]));

  // u1: no overlap, wrap
  detector_sequencia_param #(.NBITS_PADRAO(3), .PADRAO(3'b111), .NBITS_CONTAGEM(4),
    .SOBREPOSICAO(1'b0), .SATURA(1'b0)) u1 (
    .clk_2(clk_2), .reset(reset), .bit_valido(bit_valido), .bit_entrada(bit_entrada),
    .limpa_contagem(limpa_contagem), .load(load), .valor_inicial(valor_inicial[3:0]),
    .detectado(det_w[1]), .contagem(cnt1), .cheio(cheio_w[1]), .SEG(seg_w[1]));

  // u2: overlap, saturate
  detector_sequencia_param #(.NBITS_PADRAO(3), .PADRAO(3'b111), .NBITS_CONTAGEM(4),
    .SOBREPOSICAO(1'b1), .SATURA(1'b1)) u2 (
    .clk_2(clk_2), .reset(reset), .bit_valido(bit_valido), .bit_entrada(bit_entrada),
    .limpa_contagem(limpa_contagem), .load(load), .valor_inicial(valor_inicial[3:0]),
    .detectado(det_w[2]), .contagem(cnt2), .cheio(cheio_w[2]), .SEG(seg_w[2]));

  // u3: 5-bit pattern 10110, 5-bit counter, overlap, saturate
  detector_sequencia_param #(.NBITS_PADRAO(5), .PADRAO(5'b10110), .NBITS_CONTAGEM(5),
    .SOBREPOSICAO(1'b1), .SATURA(1'b1)) u3 (
    .clk_2(clk_2), .reset(reset), .bit_valido(bit_valido), .bit_entrada(bit_entrada),
    .limpa_contagem(limpa_contagem), .load(load), .valor_inicial(valor_inicial),
    .detectado(det_w[3]), .contagem(cnt3), .cheio(cheio_w[3]), .SEG(seg_w[3]));

  // Reference configuration table
  int P_N   [4] = '{3, 3, 3, 5};
  int P_PAT [4] = '{7, 7, 7, 22};
  bit P_OVL [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit P_SAT [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  int P_MAX [4] = '{15, 15, 15, 31};

  logic [7:0] SEG_TBL [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Reference model state: accepted bits since last restart, plus expectations
  bit hist [4][$];
  int exp_cnt   [4];
  bit exp_det   [4];
  bit exp_cheio [4];

  int testes = 0;
  int falhas = 0;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    testes++;
    if (obs !== esp) begin
      falhas++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  task automatic modelo_passo(input int i, input bit rst, input bit v, input bit b,
                              input bit clr, input bit ld, input int vi);
    bit casa;
    int val;
    casa = 1'b0;
    if (rst) begin
      hist[i].delete();
      exp_cnt[i]   = 0;
      exp_cheio[i] = 1'b0;
      exp_det[i]   = 1'b0;
      return;
    end
    if (v) begin
      hist[i].push_back(b);
      if (hist[i].size() >= P_N[i]) begin
        val = 0;
        for (int k = hist[i].size() - P_N[i]; k < hist[i].size(); k++)
          val = (val << 1) | int'(hist[i][k]);
        casa = (val == P_PAT[i]);
      end
      while (hist[i].size() > P_N[i]) void'(hist[i].pop_front());
      if (casa && !P_OVL[i]) hist[i].delete();
    end
    exp_det[i] = casa;
    if (clr) begin
      exp_cnt[i] = 0;
      exp_cheio[i] = 1'b0;
    end else if (ld) begin
      exp_cnt[i] = vi & P_MAX[i];
      exp_cheio[i] = 1'b0;
    end else if (casa) begin
      if (exp_cnt[i] == P_MAX[i]) begin
        exp_cheio[i] = 1'b1;
        exp_cnt[i]   = P_SAT[i] ? P_MAX[i] : 0;
      end else begin
        exp_cnt[i]++;
      end
    end
  endtask

  task automatic compara_todos();
    for (int i = 0; i < 4; i++) begin
      verifica($sformatf("u%0d_det", i),   32'(det_w[i]),   32'(exp_det[i]));
      verifica($sformatf("u%0d_cnt", i),   32'(cnt_w[i]),   32'(exp_cnt[i]));
      verifica($sformatf("u%0d_cheio", i), 32'(cheio_w[i]), 32'(exp_cheio[i]));
      verifica($sformatf("u%0d_seg", i),   32'(seg_w[i]),   32'(SEG_TBL[exp_cnt[i] % 16]));
    end
  endtask

  // Drive one cycle of inputs, advance model on the edge, compare on the falling edge
  task automatic ciclo(input bit rst, input bit v, input bit b, input bit clr,
                       input bit ld, input logic [4:0] vi);
    reset          = rst;
    bit_valido     = v;
    bit_entrada    = b;
    limpa_contagem = clr;
    load           = ld;
    valor_inicial  = vi;
    @(posedge clk_2);
    for (int i = 0; i < 4; i++) modelo_passo(i, rst, v, b, clr, ld, int'(vi));
    @(negedge clk_2);
    compara_todos();
  endtask

  task automatic bit1(input bit b);
    ciclo(1'b0, 1'b1, b, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic rst_ciclo();
    ciclo(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    @(negedge clk_2);
    rst_ciclo();
    rst_ciclo();
    verifica("reset_seg", 32'(seg_w[0]), 32'h3F);
    verifica("reset_cnt", 32'(cnt_w[0]), 32'd0);

    // Five 1s: overlap gives 3 matches, no-overlap gives 1
    for (int k = 0; k < 5; k++) bit1(1'b1);
    verifica("ovl5_cnt", 32'(cnt_w[0]), 32'd3);
    verifica("ovl5_seg", 32'(seg_w[0]), 32'h4F);
    verifica("ovl5_cheio", 32'(cheio_w[0]), 32'd0);
    verifica("novl5_cnt", 32'(cnt_w[1]), 32'd1);

    // Six 1s without overlap: matches after bits 3 and 6
    rst_ciclo();
    for (int k = 0; k < 6; k++) bit1(1'b1);
    verifica("novl6_cnt", 32'(cnt_w[1]), 32'd2);
    verifica("novl6_seg", 32'(seg_w[1]), 32'h5B);

    // Invalid cycle is ignored
    rst_ciclo();
    bit1(1'b1);
    ciclo(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    bit1(1'b1);
    verifica("gap_nodet", 32'(det_w[0]), 32'd0);
    bit1(1'b1);
    verifica("gap_det", 32'(det_w[0]), 32'd1);
    verifica("gap_cnt", 32'(cnt_w[0]), 32'd1);

    // Load E then two matches: wrap vs saturate, then clear
    rst_ciclo();
    ciclo(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'h0E);
    bit1(1'b1); bit1(1'b1); bit1(1'b1);
    verifica("ld_wrap_F", 32'(cnt_w[0]), 32'hF);
    bit1(1'b1);
    verifica("ld_wrap_0", 32'(cnt_w[0]), 32'h0);
    verifica("ld_wrap_cheio", 32'(cheio_w[0]), 32'd1);
    verifica("ld_sat_F", 32'(cnt_w[2]), 32'hF);
    verifica("ld_sat_cheio", 32'(cheio_w[2]), 32'd1);
    ciclo(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    verifica("clr_cnt", 32'(cnt_w[2]), 32'd0);
    verifica("clr_cheio", 32'(cheio_w[2]), 32'd0);

    // Reset mid-stream discards partial window
    rst_ciclo();
    bit1(1'b1); bit1(1'b1);
    rst_ciclo();
    bit1(1'b1);
    verifica("midrst_det", 32'(det_w[0]), 32'd0);
    verifica("midrst_seg", 32'(seg_w[0]), 32'h3F);
    bit1(1'b1); bit1(1'b1);
    verifica("midrst_cnt", 32'(cnt_w[0]), 32'd1);

    // Load coincident with the completing bit
    rst_ciclo();
    bit1(1'b1); bit1(1'b1);
    ciclo(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5);
    verifica("ldmatch_det", 32'(det_w[0]), 32'd1);
    verifica("ldmatch_cnt", 32'(cnt_w[0]), 32'd5);

    // Randomised stream with occasional control events
    for (int n = 0; n < 3000; n++) begin
      ciclo(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 59) == 0),
            5'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
